// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver and the datapath condition mux.
package branch_pkg;

    // Branch opcodes understood by the resolver
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_BLE = 6'h06;
    localparam logic [5:0] OP_BGT = 6'h07;

    // Condition select codes consumed by the condition mux
    typedef enum logic [1:0] {
        BC_EQ = 2'b00,
        BC_NE = 2'b01,
        BC_GT = 2'b10,
        BC_LE = 2'b11
    } branch_ctrl_t;

    // Resolver sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_RES  = 2'b10
    } br_state_t;

    // Opcode to condition select; the ble/bgt opcode LSBs do not line up with
    // the select codes, so the mapping is explicit rather than opcode[1:0].
    function automatic branch_ctrl_t decode_op(input logic [5:0] op);
        case (op)
            OP_BEQ:  return BC_EQ;
            OP_BNE:  return BC_NE;
            OP_BGT:  return BC_GT;
            OP_BLE:  return BC_LE;
            default: return BC_EQ;
        endcase
    endfunction

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLE) || (op == OP_BGT);
    endfunction

endpackage

// File: rtl/branch_resolver_cond_sel.sv
// branch_cond_sel: combinational 4:1 select of the branch condition from the
// Zero/Gt flags, shared with the datapath condition mux.
module branch_cond_sel
    import branch_pkg::*;
(
    input  branch_ctrl_t i_branch_ctrl,
    input  logic         i_zero,
    input  logic         i_gt,
    output logic         o_cond
);

    // Pick the flag (or its complement) named by the select code
    always_comb begin
        o_cond = 1'b0;
        case (i_branch_ctrl)
            BC_EQ:   o_cond = i_zero;
            BC_NE:   o_cond = ~i_zero;
            BC_GT:   o_cond = i_gt;
            BC_LE:   o_cond = ~i_gt;
            default: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: multicycle branch evaluation (IDLE -> CMP -> RES).
// Operands latched on start, flags/target registered on the CMP edge,
// registered done/pc_write_cond pulse after the RES edge.
// Optional statistics counters: define BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] pc,
    input  logic [15:0]       imm,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              gt,
    output logic [1:0]        branch_ctrl,
    output logic              taken,
    output logic              pc_write_cond,
    output logic [DATA_W-1:0] target,
    output logic              err
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       not_taken_cnt
`endif
);

    import branch_pkg::*;

    br_state_t         r_state, w_next;
    logic [5:0]        r_opcode;
    logic [DATA_W-1:0] r_a, r_b, r_pc;
    logic [15:0]       r_imm;
    logic              r_zero, r_gt, r_err, r_done;
    branch_ctrl_t      r_bc;
    logic [DATA_W-1:0] r_target;

    logic [DATA_W:0]   w_diff;
    logic              w_zero, w_gt, w_cond, w_taken;
    logic [DATA_W-1:0] w_offset, w_target;

    // Sign-extended subtract keeps gt correct across signed overflow
    assign w_diff   = {r_a[DATA_W-1], r_a} - {r_b[DATA_W-1], r_b};
    assign w_zero   = (w_diff[DATA_W-1:0] == '0);
    assign w_gt     = ~w_diff[DATA_W] & ~w_zero;
    assign w_offset = {{(DATA_W-18){r_imm[15]}}, r_imm, 2'b00};
    assign w_target = r_pc + w_offset + {{(DATA_W-3){1'b0}}, 3'b100};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: start only matters in IDLE, the rest is a fixed sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_CMP;
            ST_CMP:  w_next = ST_RES;
            ST_RES:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture the request on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_pc     <= '0;
            r_imm    <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_opcode <= opcode;
            r_a      <= op_a;
            r_b      <= op_b;
            r_pc     <= pc;
            r_imm    <= imm;
        end
    end

    // Register flags, select code, error and target on the CMP edge; they hold until the next one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero   <= 1'b0;
            r_gt     <= 1'b0;
            r_bc     <= BC_EQ;
            r_err    <= 1'b0;
            r_target <= '0;
        end else if (r_state == ST_CMP) begin
            r_zero   <= w_zero;
            r_gt     <= w_gt;
            r_bc     <= decode_op(r_opcode);
            r_err    <= ~is_branch_op(r_opcode);
            r_target <= w_target;
        end
    end

    // Completion pulse registered on the RES edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_done <= 1'b0;
        else       r_done <= (r_state == ST_RES);
    end

    branch_cond_sel u_cond_sel (
        .i_branch_ctrl (r_bc),
        .i_zero        (r_zero),
        .i_gt          (r_gt),
        .o_cond        (w_cond)
    );

    assign w_taken       = w_cond & ~r_err;
    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign zero          = r_zero;
    assign gt            = r_gt;
    assign branch_ctrl   = r_bc;
    assign taken         = w_taken;
    assign pc_write_cond = w_taken & r_done;
    assign target        = r_target;
    assign err           = r_err;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] r_taken_cnt, r_not_taken_cnt;

    // Saturating outcome counters, one update per resolved valid branch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_taken_cnt     <= '0;
            r_not_taken_cnt <= '0;
        end else if (r_state == ST_RES && !r_err) begin
            if (w_taken && r_taken_cnt != '1)
                r_taken_cnt <= r_taken_cnt + 16'd1;
            else if (!w_taken && r_not_taken_cnt != '1)
                r_not_taken_cnt <= r_not_taken_cnt + 16'd1;
        end
    end

    assign taken_cnt     = r_taken_cnt;
    assign not_taken_cnt = r_not_taken_cnt;
`else
    // No statistics logic in this build
`endif

endmodule
